// File: rtl/fetch_if.sv
// Fetch stage bus: imem request/response plus decode handoff.
// master = fetch side, slave = memory/decode side.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] code;
  logic [31:0] pc;
  logic        code_valid;
  logic        code_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output code,
    output pc,
    output code_valid,
    input  code_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  code,
    input  pc,
    input  code_valid,
    output code_ready
  );
endinterface

// File: rtl/fetch.sv
// TinyRisc-V fetch stage: PC owner, credit-limited imem
// requester, in-order response FIFO, redirect flush/drop.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_if.master     bus,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic        run_q, run_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] rpc_q, rpc_d;
  cnt_t        out_q, out_d;
  cnt_t        drop_q, drop_d;
  cnt_t        cnt_q, cnt_d;
  ptr_t        rd_q, rd_d;
  ptr_t        wr_q, wr_d;
  logic [31:0] code_mem_q [DEPTH];
  logic [31:0] code_mem_d [DEPTH];
  logic [31:0] pc_mem_q [DEPTH];
  logic [31:0] pc_mem_d [DEPTH];

  logic        req_w;
  logic        credit_ok;
  logic [CW:0] used;
  logic        fire;
  logic        pop;
  logic        push;
  logic        dropping;

  // Credits cover buffered plus in-flight words, so the
  // FIFO can never overflow; only registered state used.
  always_comb begin
    used      = {1'b0, cnt_q} + {1'b0, out_q};
    credit_ok = used < (CW+1)'(DEPTH);
    req_w     = run_q & credit_ok;
  end

  assign bus.imem_req   = req_w;
  assign bus.imem_addr  = fpc_q;
  assign bus.code_valid = cnt_q != '0;
  assign bus.code       = code_mem_q[rd_q];
  assign bus.pc         = pc_mem_q[rd_q];

  // Next-state: issue, response, pop; redirect overrides.
  always_comb begin
    run_d      = 1'b1;
    fpc_d      = fpc_q;
    rpc_d      = rpc_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    code_mem_d = code_mem_q;
    pc_mem_d   = pc_mem_q;

    fire     = req_w & bus.imem_gnt;
    pop      = (cnt_q != '0) & bus.code_ready;
    dropping = drop_q != '0;
    push     = bus.imem_rvalid & ~dropping & ~redirect;

    out_d = out_q + cnt_t'(fire) - cnt_t'(bus.imem_rvalid);
    cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

    if (fire) begin
      fpc_d = fpc_q + 32'd4;
    end

    if (bus.imem_rvalid && dropping) begin
      drop_d = drop_q - cnt_t'(1);
    end

    if (push) begin
      code_mem_d[wr_q] = bus.imem_rdata;
      pc_mem_d[wr_q]   = rpc_q;
      rpc_d            = rpc_q + 32'd4;
      wr_d             = wr_q + ptr_t'(1);
    end

    if (pop) begin
      rd_d = rd_q + ptr_t'(1);
    end

    // Every in-flight request is stale after a redirect,
    // including one granted in this very cycle.
    if (redirect) begin
      fpc_d  = redirect_pc;
      rpc_d  = redirect_pc;
      drop_d = out_d;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end
  end

  // Control and pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      fpc_q  <= RESET_PC;
      rpc_q  <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      run_q  <= run_d;
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  // FIFO storage; reset contents give code=0, pc=RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_mem_q[i] <= '0;
        pc_mem_q[i]   <= RESET_PC;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        code_mem_q[i] <= code_mem_d[i];
        pc_mem_q[i]   <= pc_mem_d[i];
      end
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(bus.imem_rvalid && cnt_q == cnt_t'(DEPTH))
  );

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: reset/stream/backpressure table plus
// directed stall, redirect, reset and randomized model run.
module tb_fetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;

  fetch_if b();

  fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (b),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        cv;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
    int          ep;
  } pend_t;

  typedef struct {
    logic [31:0] c;
    logic [31:0] p;
  } exp_t;

  pend_t       pend[$];
  exp_t        expq[$];
  logic [31:0] mfpc;
  int          epoch;
  int          cyc;
  int          rv_pct;
  int          n_vec;
  int          n_err;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // One cycle: check outputs against the model at the
  // negedge, drive inputs, then advance the model.
  task automatic step(input bit g, input bit r, input bit rd,
                      input logic [31:0] rp, input int lat);
    bit    rv;
    bit    s_req;
    bit    s_cv;
    pend_t h;
    s_req = b.imem_req;
    s_cv  = b.code_valid;
    chk("valid", {31'd0, s_cv}, {31'd0, expq.size() != 0});
    if (s_cv && expq.size() != 0) begin
      chk("code", b.code, expq[0].c);
      chk("pc", b.pc, expq[0].p);
    end
    if (cyc > 0)
      chk("req", {31'd0, s_req},
          {31'd0, (expq.size() + pend.size()) < DEPTH});
    if (s_req) chk("addr", b.imem_addr, mfpc);
    rv = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc &&
        $urandom_range(0, 99) < rv_pct)
      rv = 1'b1;
    b.imem_gnt    = g;
    b.imem_rvalid = rv;
    b.imem_rdata  = rv ? img(pend[0].a) : $urandom;
    b.code_ready  = r;
    redirect      = rd;
    redirect_pc   = rp;
    @(posedge clk);
    if (s_cv && r && expq.size() > 0) void'(expq.pop_front());
    if (s_req && g) begin
      pend.push_back('{mfpc, cyc + lat, epoch});
      mfpc = mfpc + 32'd4;
    end
    if (rv) begin
      h = pend.pop_front();
      if (!rd && h.ep == epoch) expq.push_back('{img(h.a), h.a});
    end
    if (rd) begin
      expq.delete();
      epoch++;
      mfpc = rp;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    b.imem_gnt    = 1'b0;
    b.imem_rvalid = 1'b0;
    b.imem_rdata  = '0;
    b.code_ready  = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = '0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_req", {31'd0, b.imem_req}, 32'd0);
      chk("rst_cv", {31'd0, b.code_valid}, 32'd0);
      chk("rst_pc", b.pc, RPC);
      chk("rst_code", b.code, 32'd0);
    end
    pend.delete();
    expq.delete();
    mfpc  = RPC;
    epoch = 0;
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  vec_t        tbl[18];
  logic [31:0] a0;
  bit          g, r, rd;
  logic [31:0] rp;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rv_pct = 100;
    rst_n  = 1'b0;
    tbl = '{
      '{1, 1, 0, 32'h00, 0, 32'h00},
      '{1, 1, 1, 32'h00, 0, 32'h00},
      '{1, 1, 1, 32'h04, 0, 32'h00},
      '{1, 1, 1, 32'h08, 1, 32'h00},
      '{1, 1, 1, 32'h0C, 1, 32'h04},
      '{1, 1, 1, 32'h10, 1, 32'h08},
      '{1, 0, 1, 32'h14, 1, 32'h0C},
      '{1, 0, 1, 32'h18, 1, 32'h0C},
      '{1, 0, 0, 32'h1C, 1, 32'h0C},
      '{1, 0, 0, 32'h1C, 1, 32'h0C},
      '{1, 0, 0, 32'h1C, 1, 32'h0C},
      '{1, 0, 0, 32'h1C, 1, 32'h0C},
      '{1, 1, 0, 32'h1C, 1, 32'h0C},
      '{1, 1, 1, 32'h1C, 1, 32'h10},
      '{1, 1, 1, 32'h20, 1, 32'h14},
      '{1, 1, 1, 32'h24, 1, 32'h18},
      '{1, 1, 1, 32'h28, 1, 32'h1C},
      '{1, 1, 1, 32'h2C, 1, 32'h20}
    };

    // Reset, fill, stream, backpressure and release.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      chk($sformatf("tbl%0d_req", k), {31'd0, b.imem_req},
          {31'd0, tbl[k].req});
      chk($sformatf("tbl%0d_addr", k), b.imem_addr, tbl[k].addr);
      chk($sformatf("tbl%0d_cv", k), {31'd0, b.code_valid},
          {31'd0, tbl[k].cv});
      if (tbl[k].cv) begin
        chk($sformatf("tbl%0d_pc", k), b.pc, tbl[k].pc);
        chk($sformatf("tbl%0d_code", k), b.code, img(tbl[k].pc));
      end
      step(tbl[k].gnt, tbl[k].rdy, 1'b0, '0, 1);
    end

    // Grant withheld: address must hold, then advance by 4.
    do_reset();
    repeat (4) step(1'b1, 1'b1, 1'b0, '0, 1);
    a0 = b.imem_addr;
    repeat (5) begin
      chk("stall_req", {31'd0, b.imem_req}, 32'd1);
      chk("stall_addr", b.imem_addr, a0);
      step(1'b0, 1'b1, 1'b0, '0, 1);
    end
    step(1'b1, 1'b1, 1'b0, '0, 1);
    chk("stall_next", b.imem_addr, a0 + 32'd4);

    // Redirect with words in flight and one buffered.
    do_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0, '0, 2);
    step(1'b1, 1'b0, 1'b1, 32'h100, 2);
    chk("redir_flush", {31'd0, b.code_valid}, 32'd0);
    for (int i = 0; i < 20 && !b.code_valid; i++)
      step(1'b1, 1'b1, 1'b0, '0, 2);
    chk("redir_seen", {31'd0, b.code_valid}, 32'd1);
    chk("redir_pc", b.pc, 32'h100);
    chk("redir_code", b.code, img(32'h100));
    step(1'b1, 1'b1, 1'b0, '0, 2);
    chk("redir_pc2", b.pc, 32'h104);

    // Randomized traffic with redirects and wrap targets.
    do_reset();
    rv_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      g  = $urandom_range(0, 3) != 0;
      r  = $urandom_range(0, 3) != 0;
      rd = $urandom_range(0, 19) == 0;
      rp = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0
                                       : ($urandom & 32'h0000_FFFC);
      step(g, r, rd, rp, $urandom_range(1, 3));
    end

    // Reset mid-stream with requests outstanding.
    for (int i = 0; i < 200 && pend.size() < 2; i++)
      step(1'b1, 1'b0, 1'b0, '0, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_req", {31'd0, b.imem_req}, 32'd0);
    chk("mid_cv", {31'd0, b.code_valid}, 32'd0);
    chk("mid_pc", b.pc, RPC);
    chk("mid_code", b.code, 32'd0);
    do_reset();
    rv_pct = 100;
    repeat (2) step(1'b1, 1'b1, 1'b0, '0, 1);
    chk("post_rst_addr", b.imem_addr, RPC + 32'd4);
    repeat (20) step(1'b1, 1'b1, 1'b0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
